// File: rtl/ic_refill_ctrl.sv
// Instruction-cache refill controller: issues one DDR burst read on a miss, drains the
// DDR-to-icache FIFO and writes the returned instructions into the cache RAM.
module ic_refill_ctrl #(
    parameter int unsigned DDR_ADDR_WIDTH   = 28,
    parameter int unsigned ISA_WIDTH        = 30,
    parameter int unsigned ISA_DEPTH        = 72,
    parameter int unsigned CACHE_ADDR_WIDTH = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        miss_req,
    input  logic [DDR_ADDR_WIDTH-1:0]   miss_addr,
    output logic                        ins_read_req,
    output logic [DDR_ADDR_WIDTH-1:0]   ins_read_addr,
    output logic [7:0]                  ins_read_len,
    input  logic                        ins_reading,
    input  logic [ISA_WIDTH+8:0]        fifo_dout,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    output logic                        cache_wr_en,
    output logic [CACHE_ADDR_WIDTH-1:0] cache_wr_addr,
    output logic [ISA_WIDTH-1:0]        cache_wr_data,
    output logic                        busy,
    output logic                        refill_done,
    output logic                        refill_err
);

    localparam logic [7:0] DEPTH = 8'(ISA_DEPTH);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDrain, StDone} state_e;

    state_e                    state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      rd_pend_q, rd_pend_d;
    logic                      err_q, err_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                len_q, len_d;

    // FIFO entry fields: {ins, rd_cnt, valid}
    logic [ISA_WIDTH-1:0] ent_ins;
    logic [7:0]           ent_cnt;
    logic                 ent_valid;

    assign ent_ins   = fifo_dout[ISA_WIDTH+8:9];
    assign ent_cnt   = fifo_dout[8:1];
    assign ent_valid = fifo_dout[0];

    assign ins_read_addr = addr_q;
    assign ins_read_len  = len_q;
    assign refill_err    = err_q;

    // State and datapath registers; async reset returns to idle with everything cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            rd_pend_q <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            len_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
        end
    end

    // Next-state, FIFO read handshake, entry processing and outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_pend_d     = 1'b0;
        err_d         = err_q;
        addr_d        = addr_q;
        len_d         = len_q;
        ins_read_req  = 1'b0;
        fifo_rd_en    = 1'b0;
        cache_wr_en   = 1'b0;
        cache_wr_addr = '0;
        cache_wr_data = '0;
        busy          = (state_q != StIdle);
        refill_done   = 1'b0;

        // One read in flight at most; stop pulling once the block is complete
        if ((state_q == StWait || state_q == StDrain) && !fifo_empty && !rd_pend_q &&
            (cnt_q != DEPTH)) begin
            fifo_rd_en = 1'b1;
            rd_pend_d  = 1'b1;
        end

        // Entry read last cycle is now on fifo_dout; out-of-range still counts so we terminate
        if (rd_pend_q && ent_valid) begin
            cnt_d = cnt_q + 8'd1;
            if (ent_cnt < DEPTH) begin
                cache_wr_en   = 1'b1;
                cache_wr_addr = ent_cnt[CACHE_ADDR_WIDTH-1:0];
                cache_wr_data = ent_ins;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            StIdle: begin
                if (miss_req) begin
                    addr_d  = miss_addr;
                    len_d   = DEPTH;
                    cnt_d   = 8'd0;
                    err_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                ins_read_req = 1'b1;
                if (ins_reading) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (fifo_rd_en) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (cnt_q == DEPTH) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                refill_done = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Scoreboard bench for ic_refill_ctrl: a queue-based FIFO model feeds entries, a reference
// model predicts the cache writes, and a negedge monitor pops and compares them.
module tb_ic_refill_ctrl;

    localparam int AW = 28;
    localparam int IW = 30;
    localparam int DEPTH = 72;
    localparam int CW = 7;

    logic          clk;
    logic          rst;
    logic          miss_req;
    logic [AW-1:0] miss_addr;
    logic          ins_read_req;
    logic [AW-1:0] ins_read_addr;
    logic [7:0]    ins_read_len;
    logic          ins_reading;
    logic [IW+8:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic          cache_wr_en;
    logic [CW-1:0] cache_wr_addr;
    logic [IW-1:0] cache_wr_data;
    logic          busy;
    logic          refill_done;
    logic          refill_err;

    ic_refill_ctrl #(
        .DDR_ADDR_WIDTH  (AW),
        .ISA_WIDTH       (IW),
        .ISA_DEPTH       (DEPTH),
        .CACHE_ADDR_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .miss_req     (miss_req),
        .miss_addr    (miss_addr),
        .ins_read_req (ins_read_req),
        .ins_read_addr(ins_read_addr),
        .ins_read_len (ins_read_len),
        .ins_reading  (ins_reading),
        .fifo_dout    (fifo_dout),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .cache_wr_en  (cache_wr_en),
        .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data),
        .busy         (busy),
        .refill_done  (refill_done),
        .refill_err   (refill_err)
    );

    int checks = 0;
    int failures = 0;
    int writes_cnt = 0;
    int done_cnt = 0;
    int req_rises = 0;
    int reads_cnt = 0;
    int gap = 0;
    bit starve_mode = 0;
    logic req_prev = 1'b0;

    logic [IW+8:0]    fq[$];     // FIFO contents
    logic [CW+IW-1:0] exp_q[$];  // expected {addr, data} cache writes

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [IW+8:0] mk(input logic v, input logic [7:0] c,
                                         input logic [IW-1:0] ins);
        return {ins, c, v};
    endfunction

    // FIFO model: dout valid the cycle after rd_en; optional random starvation gap after each read
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            checks++;
            if (fifo_empty || fq.size() == 0) begin
                failures++;
                $display("FAIL rd_en_while_empty: got rd_en=1 empty=%0b expected rd_en=0",
                         fifo_empty);
            end else begin
                fifo_dout <= fq.pop_front();
                reads_cnt++;
            end
            gap = starve_mode ? int'($urandom_range(0, 5)) : 0;
        end else if (gap > 0) begin
            gap--;
        end
    end

    // Monitor: compare every cache write against the scoreboard, count pulses and requests
    always @(negedge clk) begin
        if (!rst) begin
            if (cache_wr_en) begin
                writes_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: got addr=%0d data=%0h expected none",
                             cache_wr_addr, cache_wr_data);
                end else begin
                    logic [CW+IW-1:0] e;
                    e = exp_q.pop_front();
                    if ({cache_wr_addr, cache_wr_data} !== e) begin
                        failures++;
                        $display("FAIL write_content: got addr=%0d data=%0h expected addr=%0d data=%0h",
                                 cache_wr_addr, cache_wr_data, e[CW+IW-1:IW], e[IW-1:0]);
                    end
                end
            end
            if (refill_done) done_cnt++;
            if (ins_read_req && !req_prev) req_rises++;
        end
        req_prev   = ins_read_req;
        fifo_empty = (fq.size() == 0) || (gap != 0);
    end

    // Build entries for a mode, run the reference model and load the FIFO
    task automatic load(input int mode, output int n_writes, output int consumed,
                        output int leftover, output bit exp_err);
        logic [IW+8:0] ents[$];
        int counted;
        counted  = 0;
        consumed = 0;
        n_writes = 0;
        exp_err  = 1'b0;
        for (int k = 0; k < ((mode == 4) ? 75 : DEPTH); k++) begin
            logic [IW-1:0] ins;
            ins = (mode == 2) ? IW'($urandom) : IW'(32'h1000 + k);
            if (mode == 3 && k == 10) ents.push_back(mk(1'b1, 8'd80, IW'($urandom)));
            ents.push_back(mk(1'b1, 8'(k), ins));
            if (mode == 1) ents.push_back(mk(1'b0, 8'($urandom), IW'($urandom)));
        end
        // Reference: the first DEPTH valid entries are consumed, in-range ones become writes
        foreach (ents[i]) begin
            logic [7:0] c;
            c = ents[i][8:1];
            fq.push_back(ents[i]);
            if (counted < DEPTH) begin
                consumed++;
                if (ents[i][0]) begin
                    counted++;
                    if (c < 8'(DEPTH)) begin
                        exp_q.push_back({c[CW-1:0], ents[i][IW+8:9]});
                        n_writes++;
                    end else begin
                        exp_err = 1'b1;
                    end
                end
            end
        end
        leftover = ents.size() - consumed;
    endtask

    // Accept a miss and complete the read-request handshake
    task automatic start_miss(input logic [AW-1:0] a);
        int hold;
        @(posedge clk); #1;
        miss_req  = 1'b1;
        miss_addr = a;
        @(posedge clk); #1;
        miss_req = 1'b0;
        chk("req_asserted", {ins_read_req, busy, refill_err}, 3'b110);
        chk("req_addr_len", {ins_read_addr, ins_read_len}, {a, 8'(DEPTH)});
        hold = $urandom_range(0, 4);
        repeat (hold) @(posedge clk);
        #1;
        chk("req_held", ins_read_req, 1'b1);
        ins_reading = 1'b1;
        @(posedge clk); #1;
        ins_reading = 1'b0;
        chk("req_dropped", ins_read_req, 1'b0);
    endtask

    task automatic run(input int mode);
        int n_writes, consumed, leftover;
        bit exp_err;
        int w0, d0, r0, rd0;
        int i;
        logic [AW-1:0] a;
        load(mode, n_writes, consumed, leftover, exp_err);
        starve_mode = (mode == 2);
        w0  = writes_cnt;
        d0  = done_cnt;
        r0  = req_rises;
        rd0 = reads_cnt;
        a   = (mode == 0) ? AW'(32'h0000100) : AW'($urandom);
        start_miss(a);
        if (mode == 4) begin
            for (i = 0; i < 500 && writes_cnt < w0 + 5; i++) @(posedge clk);
            chk("drain_reached", 32'(writes_cnt >= w0 + 5), 32'd1);
            #1 miss_req = 1'b1;
            miss_addr = AW'($urandom);
            repeat (3) @(posedge clk);
            #1 miss_req = 1'b0;
        end
        for (i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (done_cnt > d0) break;
        end
        chk("done_in_time", 32'(done_cnt > d0), 32'd1);
        chk("busy_fell", {busy, refill_done}, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("write_count", 32'(writes_cnt - w0), 32'(n_writes));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("read_count", 32'(reads_cnt - rd0), 32'(consumed));
        chk("fifo_leftover", 32'(fq.size()), 32'(leftover));
        chk("single_request", 32'(req_rises - r0), 32'd1);
        chk("refill_err", refill_err, exp_err);
        chk("idle_after", {busy, ins_read_req, fifo_rd_en}, 3'b000);
        starve_mode = 1'b0;
        fq.delete();
        exp_q.delete();
        repeat (8) @(posedge clk);
    endtask

    initial begin
        int n_writes, consumed, leftover;
        bit exp_err;
        int i, w0;
        rst         = 1'b1;
        miss_req    = 1'b0;
        miss_addr   = '0;
        ins_reading = 1'b0;
        #1;
        chk("reset_outputs", {ins_read_req, fifo_rd_en, cache_wr_en, cache_wr_addr,
                              cache_wr_data, busy, refill_done, refill_err, ins_read_addr,
                              ins_read_len}, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        run(0);  // nominal
        run(1);  // interleaved invalid entries
        run(2);  // starved FIFO
        run(3);  // out-of-range rd_cnt, err stays set after done
        run(0);  // next miss clears err
        run(4);  // extra entries + miss during drain

        // Reset in the middle of a drain
        load(0, n_writes, consumed, leftover, exp_err);
        w0 = writes_cnt;
        start_miss(AW'($urandom));
        for (i = 0; i < 1000 && writes_cnt < w0 + 30; i++) begin
            @(posedge clk); #1;
        end
        chk("reached_30_writes", 32'(writes_cnt >= w0 + 30), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midreset_outputs", {ins_read_req, fifo_rd_en, cache_wr_en, cache_wr_addr,
                                 cache_wr_data, busy, refill_done, refill_err, ins_read_addr,
                                 ins_read_len}, '0);
        fq.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        run(0);  // clean refill after reset

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute safety net against a hung run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
